wade_uart_tx: RTL and testbench
===============================

# wade_uart_tx

Serial output stage for `tt_um_wade`. It consumes bytes produced by the core logic through a valid/ready handshake and buffers them in a small FIFO. It transmits them as 8N1 UART frames on a single output pin, which the top level routes to `uo_out[0]`. Back-to-back bytes are sent without idle gaps between frames.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Minimum 2.
- `FIFO_DEPTH`, default 4: byte buffer depth. Power of two, minimum 2.

Ports:
- `clk`  in  1: single clock. All state is on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `ena`  in  1: design enable, from the top-level `ena`.
- `in_data`  in  8: byte to transmit.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the FIFO accepts a byte this cycle.
- `tx`  out  1: UART serial line. Idle high.
- `busy`  out  1: a frame is in progress.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: number of bytes buffered.

## Operation

**Reset (asynchronous)**
- `tx`=1, `busy`=0, `fifo_count`=0.
- FSM goes to IDLE; bit and baud counters are cleared; FIFO contents are discarded.
- Reset asserted mid-frame returns `tx` to 1 immediately, without waiting for a clock edge.

**Input handshake**
- `in_ready` = `ena` && (`fifo_count` != `FIFO_DEPTH`). This is combinational.
- `in_ready` does not depend on a same-cycle pop. When the FIFO is full, no push happens even if a pop occurs in the same cycle.
- A push occurs on a rising edge where `in_valid` && `in_ready`.
- `in_data` is ignored when no push occurs.

**FIFO**
- Circular buffer with wrap-around read and write pointers.
- A push and a pop in the same cycle leave `fifo_count` unchanged, and the data ordering is preserved.

**FSM states: IDLE → START → DATA → STOP**
- **IDLE:** `tx`=1, `busy`=0. On an edge with `ena`=1 and the FIFO non-empty: pop the head byte into the shift register and go to START.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- **DATA:** `tx`=shift[0] for `CLKS_PER_BIT` cycles. Then shift right by one and increment the index. After the 8th bit, go to STOP. Bits are sent LSB first.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles. On the final edge:
  - if `ena`=1 and the FIFO is non-empty, pop and go directly to START (no idle cycle);
  - otherwise go to IDLE.
- `busy`=1 in START, DATA and STOP.

**Enable behaviour**
- `ena`=0 blocks pushes and blocks new frame starts.
- A frame already in progress completes normally.

**Output registers**
- `tx` and `busy` come from flops; they are not decoded combinationally from inputs.

## Timing

- **Frame length:** exactly 10·`CLKS_PER_BIT` cycles.
- **Start latency:** a byte pushed into an empty FIFO at edge k, with FSM in IDLE, is popped at edge k+1. `tx` is low from edge k+1.
- **Back-to-back frames:** the next start bit begins on the edge that ends the previous stop bit, with no gap.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 and reloads to 0 at every state or bit transition. There is no drift across frames.
- **`fifo_count`:** updates on the push/pop edge.
- **Throughput:** at most one byte per 10·`CLKS_PER_BIT` cycles sustained. Bursts are absorbed up to `FIFO_DEPTH`, plus one byte held in the shift register.

## Test plan

1. **Single byte:** `CLKS_PER_BIT`=4, reset, then push 0xA5.
   - `tx` sequence, each level held 4 cycles: 0,1,0,1,0,0,1,0,1,1.
   - `busy` is high for 40 cycles, then `tx`=1 and `busy`=0.
2. **Reset values:** assert `rst_n`=0 asynchronously between clock edges.
   - `tx`=1, `busy`=0, `fifo_count`=0 immediately; `in_ready`=1 with `ena`=1.
3. **Burst and FIFO full:** `FIFO_DEPTH`=4, hold `in_valid` high for 6 consecutive cycles with bytes 0x01..0x06.
   - 5 bytes are accepted (first popped at k+1).
   - `in_ready` is 0 on the 6th cycle and `fifo_count`=4.
   - The serial output carries 0x01..0x05 in order.
4. **Back-to-back frames:** push 0x00 then 0xFF.
   - `busy` stays high for 80 consecutive cycles (`CLKS_PER_BIT`=4).
   - The first stop bit is followed immediately by the second start bit.
5. **Enable gating:** drop `ena` during the DATA state of the first of two queued bytes.
   - The first frame completes; `tx` then stays 1 and `busy`=0.
   - `in_ready`=0 and `fifo_count` stays 1.
   - When `ena` returns, the second frame starts on the next edge.
6. **Reset mid-frame:** with the FIFO holding 2 bytes, assert reset during DATA.
   - `tx`=1 and `fifo_count`=0 immediately.
   - After release, no frame is emitted until a new push.

Source files
------------

// File: rtl/wade_uart_tx.sv
// wade_uart_tx: small byte FIFO feeding an 8N1 UART transmitter.
// Frames go out back-to-back while ena is high and bytes are queued.
module wade_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  // state | meaning
  // IDLE  | line high, waiting for ena and a queued byte
  // START | start bit, line low
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit, line high; may chain straight into START
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx, r_busy;

  state_t        w_state_nxt;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_tx_nxt, w_busy_nxt;
  logic          w_push, w_pop, w_nonempty, w_baud_done;

  assign in_ready    = ena && (r_count != FULL);
  assign w_push      = in_valid && in_ready;
  assign w_nonempty  = (r_count != '0);
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign tx          = r_tx;
  assign busy        = r_busy;
  assign fifo_count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (ena && w_nonempty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (ena && w_nonempty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rptr];
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output flops are loaded from the next-state view so tx changes on the transition edge.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end
endmodule

// File: tb/tb_wade_uart_tx.sv
// Bench for wade_uart_tx: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wade_uart_tx;
  localparam int C     = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, tx, busy;
  logic [2:0] fifo_count;

  wade_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference model: a byte queue plus the frame currently on the wire.
  byte unsigned m_q[$];
  bit           m_active = 1'b0;
  int           m_pos = 0;
  logic [9:0]   m_frame = 10'h3FF;

  always @(posedge clk or negedge rst_n) begin : model
    bit           push;
    byte unsigned b;
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      push = in_valid && ena && (m_q.size() < D);
      if ((!m_active || m_pos == FRAME - 1) && ena && m_q.size() > 0) begin
        b        = m_q.pop_front();
        m_frame  = {1'b1, b, 1'b0};
        m_active = 1'b1;
        m_pos    = 0;
      end else if (m_active) begin
        if (m_pos == FRAME - 1) m_active = 1'b0;
        else                    m_pos++;
      end
      if (push) m_q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    chk("tx", tx, m_active ? m_frame[m_pos / C] : 1'b1);
    chk("busy", busy, m_active);
    chk("fifo_count", fifo_count, m_q.size());
    chk("in_ready", in_ready, ena && (m_q.size() < D));
  end

  // Independent line receiver: samples mid-bit, collects data bytes.
  byte unsigned rx_q[$];
  bit           rx_on = 1'b0;
  int           rx_pos = 0;
  logic [9:0]   rx_sh = '0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_on = 1'b0;
    end else begin
      if (!rx_on) begin
        if (tx == 1'b0) begin
          rx_on  = 1'b1;
          rx_pos = 0;
        end
      end else begin
        rx_pos++;
      end
      if (rx_on && (rx_pos % C) == C / 2) rx_sh[rx_pos / C] = tx;
      if (rx_on && rx_pos == FRAME - 1) begin
        rx_on = 1'b0;
        rx_q.push_back(rx_sh[8:1]);
      end
    end
  end

  task automatic wait_busy(input logic val, input int limit, input string nm);
    int n = 0;
    while (busy !== val && n < limit) begin
      step();
      n++;
    end
    chk(nm, busy, val);
  endtask

  task automatic wait_rx(input int cnt, input int limit, input string nm);
    int n = 0;
    while (rx_q.size() < cnt && n < limit) begin
      step();
      n++;
    end
    chk(nm, rx_q.size(), cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  int           a5_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic         trace[200];
  int           run;
  int           nb;
  int           dens;
  byte unsigned rb;

  initial begin
    ena   = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_ready", in_ready, 1'b1);

    // Single byte 0xA5, literal bit sequence.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk("a5_tx", tx, a5_seq[i / C]);
      chk("a5_busy", busy, 1'b1);
      if (i == 0) chk("a5_count", fifo_count, 3'd0);
    end
    @(negedge clk);
    chk("a5_end_tx", tx, 1'b1);
    chk("a5_end_busy", busy, 1'b0);
    #1;

    // Asynchronous reset between edges.
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("areset_tx", tx, 1'b1);
    chk("areset_busy", busy, 1'b0);
    chk("areset_count", fifo_count, 3'd0);
    chk("areset_ready", in_ready, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Burst of six bytes into a depth-4 FIFO.
    rx_q.delete();
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      if (i == 6) begin
        chk("burst_ready6", in_ready, 1'b0);
        chk("burst_count6", fifo_count, 3'd4);
      end else begin
        chk("burst_ready", in_ready, 1'b1);
      end
      step();
    end
    in_valid = 1'b0;
    wait_rx(5, 6 * FRAME + 20, "burst_rx_timeout");
    for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("burst_rx_byte", rx_q[i], i + 1);
    wait_busy(1'b0, FRAME + 10, "burst_idle_timeout");
    step();

    // Back-to-back 0x00 then 0xFF.
    rx_q.delete();
    in_valid = 1'b1;
    in_data  = 8'h00;
    step();
    in_data  = 8'hFF;
    step();
    in_valid = 1'b0;
    run = 0;
    while (busy === 1'b1 && run < 200) begin
      trace[run] = tx;
      run++;
      step();
    end
    chk("b2b_busy_len", run, 2 * FRAME);
    chk("b2b_last_stop", trace[FRAME - 1], 1'b1);
    chk("b2b_next_start", trace[FRAME], 1'b0);
    chk("b2b_rx_n", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("b2b_rx0", rx_q[0], 8'h00);
      chk("b2b_rx1", rx_q[1], 8'hFF);
    end
    step();

    // Enable gating: drop ena during DATA of the first of two bytes.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    in_data  = 8'hC3;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    ena = 1'b0;
    #1;
    chk("gate_ready", in_ready, 1'b0);
    chk("gate_count", fifo_count, 3'd1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    wait_busy(1'b0, FRAME + 10, "gate_finish_timeout");
    repeat (10) begin
      chk("gate_hold_tx", tx, 1'b1);
      chk("gate_hold_busy", busy, 1'b0);
      chk("gate_hold_count", fifo_count, 3'd1);
      chk("gate_hold_ready", in_ready, 1'b0);
      step();
    end
    in_valid = 1'b0;
    ena      = 1'b1;
    step();
    chk("gate_resume_busy", busy, 1'b1);
    chk("gate_resume_tx", tx, 1'b0);
    chk("gate_resume_count", fifo_count, 3'd0);
    wait_busy(1'b0, FRAME + 10, "gate_done_timeout");
    step();

    // Reset mid-frame with two bytes still queued.
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    in_data  = 8'h22;
    step();
    in_data  = 8'h33;
    step();
    in_valid = 1'b0;
    chk("mid_count_before", fifo_count, 3'd2);
    repeat (8) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_tx", tx, 1'b1);
    chk("mid_busy", busy, 1'b0);
    chk("mid_count", fifo_count, 3'd0);
    step();
    step();
    rst_n = 1'b1;
    nb = 0;
    repeat (60) begin
      if (busy !== 1'b0 || tx !== 1'b1) nb++;
      step();
    end
    chk("mid_quiet", nb, 0);
    rx_q.delete();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    wait_rx(1, FRAME + 10, "mid_rx_timeout");
    if (rx_q.size() >= 1) chk("mid_rx_byte", rx_q[0], 8'h5A);
    wait_busy(1'b0, FRAME + 10, "mid_idle_timeout");

    // Randomized traffic with varying density and occasional ena drops.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      case ((cyc / 500) % 3)
        0:       dens = 5;
        1:       dens = 30;
        default: dens = 90;
      endcase
      in_valid = ($urandom_range(0, 99) < dens);
      rb       = 8'($urandom);
      in_data  = rb;
      if ($urandom_range(0, 99) == 0)                   ena = ~ena;
      else if (!ena && $urandom_range(0, 9) == 0)       ena = 1'b1;
      if (cyc == 2000) begin
        #($urandom_range(1, 3)) rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    ena      = 1'b1;
    nb = 0;
    while ((fifo_count != 3'd0 || busy !== 1'b0) && nb < (D + 2) * FRAME) begin
      step();
      nb++;
    end
    chk("drain_count", fifo_count, 3'd0);
    chk("drain_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
